// File: rtl/packet_parser.sv
// Receive-side packet parser: burst-reads a header/payload/CRC8 packet, verifies the
// CRC8 trailer and, on a match, burst-writes the payload to a destination buffer.
module packet_parser #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [7:0]  CRC_POLY = 8'h07
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              busy,
    output logic              done,
    output logic              crc_err,
    output logic [3:0]        hdr_byte_cnt,
    output logic [3:0]        hdr_data_sel,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [3:0] {
        S_IDLE, S_AR_HDR, S_R_HDR, S_AR_REST, S_R_REST,
        S_CHECK, S_AW, S_W, S_B, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [159:0]        buf_q, buf_d;
    logic [3:0]          bcnt_q, bcnt_d;
    logic [3:0]          dsel_q, dsel_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [7:0]          crc_q, crc_d;
    logic                err_q, err_d;

    logic [4:0]          n_words;
    logic [4:0]          n_beats;
    logic [4:0]          last_idx;
    logic                beat_last;
    logic [3:0]          last_strb;
    logic [159:0]        payload;
    logic [7:0]          crc_next;
    logic [7:0]          trailer;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] r;
        r = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] buf_byte(input logic [159:0] b, input logic [4:0] k);
        return b[{k, 3'b000} +: 8];
    endfunction

    // Packet spans byte_cnt+4 bytes; payload spans byte_cnt+1 bytes.
    assign n_words   = ({1'b0, bcnt_q} + 5'd7) >> 2;
    assign n_beats   = ({1'b0, bcnt_q} + 5'd4) >> 2;
    assign last_idx  = {1'b0, bcnt_q} + 5'd2;
    assign beat_last = (cnt_q == n_beats - 5'd1);
    assign payload   = buf_q >> 16;
    assign crc_next  = crc8_byte(crc_q, buf_byte(buf_q, cnt_q));
    assign trailer   = buf_byte(buf_q, cnt_q + 5'd1);

    always_comb begin
        case (bcnt_q[1:0])
            2'd0:    last_strb = 4'b0001;
            2'd1:    last_strb = 4'b0011;
            2'd2:    last_strb = 4'b0111;
            default: last_strb = 4'b1111;
        endcase
    end

    assign crc_err      = err_q;
    assign hdr_byte_cnt = bcnt_q;
    assign hdr_data_sel = dsel_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        bcnt_d  = bcnt_q;
        dsel_d  = dsel_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        err_d   = err_q;
        busy    = (state_q != S_IDLE) && (state_q != S_DONE);
        done    = 1'b0;
        araddr  = '0;
        arlen   = 8'd0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awaddr  = '0;
        awlen   = 8'd0;
        awvalid = 1'b0;
        wdata   = 32'd0;
        wstrb   = 4'd0;
        wlast   = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    err_d   = 1'b0;
                    state_d = S_AR_HDR;
                end
            end
            S_AR_HDR: begin
                arvalid = 1'b1;
                araddr  = src_q;
                if (arready) state_d = S_R_HDR;
            end
            S_R_HDR: begin
                rready = 1'b1;
                if (rvalid) begin
                    buf_d[31:0] = rdata;
                    bcnt_d      = rdata[3:0];
                    dsel_d      = rdata[7:4];
                    if (rdata[3:0] == 4'd0) begin
                        state_d = S_CHECK;
                        cnt_d   = 5'd0;
                        crc_d   = 8'd0;
                    end else begin
                        state_d = S_AR_REST;
                        cnt_d   = 5'd1;
                    end
                end
            end
            S_AR_REST: begin
                arvalid = 1'b1;
                araddr  = src_q + ADDR_W'(4);
                arlen   = {3'b000, n_words - 5'd2};
                if (arready) state_d = S_R_REST;
            end
            S_R_REST: begin
                rready = 1'b1;
                if (rvalid) begin
                    buf_d[{cnt_q, 5'b00000} +: 32] = rdata;
                    // rlast must coincide exactly with the final expected beat
                    if (rlast != (cnt_q == n_words - 5'd1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (rlast) begin
                        state_d = S_CHECK;
                        cnt_d   = 5'd0;
                        crc_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_CHECK: begin
                crc_d = crc_next;
                if (cnt_q == last_idx) begin
                    if (crc_next != trailer) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_AW;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                awaddr  = dst_q;
                awlen   = {3'b000, n_beats - 5'd1};
                if (awready) begin
                    state_d = S_W;
                    cnt_d   = 5'd0;
                end
            end
            S_W: begin
                wvalid = 1'b1;
                wdata  = payload[{cnt_q, 5'b00000} +: 32];
                wstrb  = beat_last ? last_strb : 4'hF;
                wlast  = beat_last;
                if (wready) begin
                    if (beat_last) state_d = S_B;
                    else           cnt_d   = cnt_q + 5'd1;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            bcnt_q  <= 4'd0;
            dsel_q  <= 4'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            bcnt_q  <= bcnt_d;
            dsel_q  <= dsel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers carry no reset; control gates every use of them.
    always_ff @(posedge clk) begin
        src_q <= src_d;
        dst_q <= dst_d;
        buf_q <= buf_d;
        crc_q <= crc_d;
    end

endmodule

// File: tb/tb_packet_parser.sv
// Bench for packet_parser: a memory-backed burst slave plus a byte-level packet model
// that derives the expected reads, CRC verdict and payload writes.
module tb_packet_parser;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic        busy, done, crc_err;
    logic [3:0]  hdr_byte_cnt, hdr_data_sel;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_data_q[$];
    logic [3:0]  w_strb_q[$];
    logic        w_last_q[$];
    logic        obs_err;
    logic [3:0]  obs_bc, obs_ds;
    int          done_cnt, extra_act;

    packet_parser #(.ADDR_W(32), .CRC_POLY(8'h07)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .busy(busy), .done(done), .crc_err(crc_err),
        .hdr_byte_cnt(hdr_byte_cnt), .hdr_data_sel(hdr_data_sel),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic logic [7:0] pkt_byte(input logic [31:0] src, input int k);
        logic [31:0] w;
        w = memrd(src + 32'(4 * (k / 4)));
        return w[8 * (k % 4) +: 8];
    endfunction

    task automatic set_byte(input logic [31:0] src, input int k, input logic [7:0] v);
        logic [31:0] a, w;
        a = src + 32'(4 * (k / 4));
        w = memrd(a);
        w[8 * (k % 4) +: 8] = v;
        mem[a] = w;
    endtask

    // CRC as the remainder of message(x) * x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input logic [31:0] src, input int nbytes);
        logic [7:0] r, cur;
        logic       top;
        r = 8'h00;
        for (int k = 0; k < nbytes + 1; k++) begin
            cur = (k < nbytes) ? pkt_byte(src, k) : 8'h00;
            for (int i = 7; i >= 0; i--) begin
                top = r[7];
                r = {r[6:0], cur[i]};
                if (top) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    task automatic make_packet(input logic [31:0] src, input int bc, input bit corrupt);
        logic [7:0] crc;
        logic [3:0] ds, bcl;
        int         bit_i;
        ds  = 4'($urandom_range(0, 15));
        bcl = 4'(bc);
        for (int w = 0; w < 5; w++) mem[src + 32'(4 * w)] = $urandom;
        set_byte(src, 0, {ds, bcl});
        crc = ref_crc(src, bc + 3);
        if (corrupt) begin
            bit_i = $urandom_range(0, 7);
            crc = crc ^ 8'(1 << bit_i);
        end
        set_byte(src, bc + 3, crc);
    endtask

    task automatic run_txn(input logic [31:0] src, input logic [31:0] dst, input int stall,
                           input bit rnd, input bit sbusy, input bit sdone, input bit rstw);
        int          ar_stall, aw_stall, w_stall, b_stall, beats_left, cyc;
        logic [31:0] raddr, h_araddr, h_wdata;
        logic [7:0]  h_arlen;
        logic [3:0]  h_wstrb;
        logic        h_wlast;
        bit          ar_held, w_held, b_pend, fin, got_done;
        ar_addr_q.delete(); ar_len_q.delete(); aw_addr_q.delete(); aw_len_q.delete();
        w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
        done_cnt = 0; extra_act = 0;
        @(negedge clk);
        src_addr = src; dst_addr = dst; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        ar_stall = rnd ? $urandom_range(0, 4) : stall;
        aw_stall = rnd ? $urandom_range(0, 4) : 0;
        w_stall  = rnd ? $urandom_range(0, 4) : stall;
        b_stall  = rnd ? $urandom_range(0, 4) : stall;
        beats_left = 0; raddr = 32'h0; h_araddr = 32'h0; h_arlen = 8'h0;
        h_wdata = 32'h0; h_wstrb = 4'h0; h_wlast = 1'b0;
        ar_held = 0; w_held = 0; b_pend = 0; fin = 0; got_done = 0; cyc = 0;
        while (!fin && cyc < 600) begin
            arready = 0; rvalid = 0; rlast = 0; rdata = $urandom;
            awready = 0; wready = 0; bvalid = 0; start = 0;
            if (done) begin
                got_done = 1; fin = 1; done_cnt++;
                obs_err = crc_err; obs_bc = hdr_byte_cnt; obs_ds = hdr_data_sel;
                chk("busy_low_at_done", busy, 0);
                if (sdone) begin
                    start = 1'b1; src_addr = src + 32'h200;
                end
            end else if (rstw && wvalid) begin
                reset = 1'b1; fin = 1;
                @(negedge clk);
                chk("rst_arvalid", arvalid, 0);
                chk("rst_rready", rready, 0);
                chk("rst_awvalid", awvalid, 0);
                chk("rst_wvalid", wvalid, 0);
                chk("rst_bready", bready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_crc_err", crc_err, 0);
                reset = 1'b0;
            end else begin
                if (ar_held) begin
                    chk("arvalid_held", arvalid, 1);
                    chk("araddr_stable", araddr, h_araddr);
                    chk("arlen_stable", arlen, h_arlen);
                end
                if (arvalid) begin
                    if (ar_stall > 0) begin
                        ar_stall--;
                        if (!ar_held) begin ar_held = 1; h_araddr = araddr; h_arlen = arlen; end
                    end else begin
                        arready = 1; ar_held = 0;
                        ar_addr_q.push_back(araddr); ar_len_q.push_back(arlen);
                        raddr = araddr; beats_left = int'(arlen) + 1;
                        ar_stall = rnd ? $urandom_range(0, 3) : 0;
                    end
                end
                if (beats_left > 0 && rready) begin
                    if (!(rnd && $urandom_range(0, 3) == 0)) begin
                        rvalid = 1; rdata = memrd(raddr); rlast = (beats_left == 1);
                        raddr = raddr + 32'd4; beats_left--;
                    end
                end
                if (awvalid) begin
                    if (aw_stall > 0) aw_stall--;
                    else begin
                        awready = 1;
                        aw_addr_q.push_back(awaddr); aw_len_q.push_back(awlen);
                    end
                end
                if (w_held) begin
                    chk("wvalid_held", wvalid, 1);
                    chk("wdata_stable", wdata, h_wdata);
                    chk("wstrb_stable", wstrb, h_wstrb);
                    chk("wlast_stable", wlast, h_wlast);
                end
                if (wvalid) begin
                    if (w_stall > 0) begin
                        w_stall--;
                        if (!w_held) begin
                            w_held = 1; h_wdata = wdata; h_wstrb = wstrb; h_wlast = wlast;
                        end
                    end else begin
                        wready = 1; w_held = 0;
                        w_data_q.push_back(wdata); w_strb_q.push_back(wstrb); w_last_q.push_back(wlast);
                        if (wlast) b_pend = 1;
                        w_stall = rnd ? $urandom_range(0, 2) : 0;
                    end
                end
                if (b_pend && bready) begin
                    if (b_stall > 0) b_stall--;
                    else begin bvalid = 1; b_pend = 0; end
                end
                if (sbusy && cyc == 4) begin
                    start = 1'b1; src_addr = src + 32'h100; dst_addr = dst + 32'h100;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!rstw) begin
            chk("txn_done_seen", got_done, 1);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) done_cnt++;
                if (arvalid || busy) extra_act++;
            end
        end
    endtask

    task automatic check_txn(input logic [31:0] src, input logic [31:0] dst);
        int          bc, ds, nwords, npay, nbeats, k;
        logic [7:0]  b0, crc, trl;
        logic [31:0] exp_data, mask;
        bit          exp_err;
        b0 = pkt_byte(src, 0);
        bc = int'(b0) % 16;
        ds = int'(b0) / 16;
        nwords = (bc + 4 + 3) / 4;
        npay   = bc + 1;
        nbeats = (npay + 3) / 4;
        crc = ref_crc(src, bc + 3);
        trl = pkt_byte(src, bc + 3);
        exp_err = (crc != trl);
        chk("hdr_byte_cnt", obs_bc, bc);
        chk("hdr_data_sel", obs_ds, ds);
        chk("crc_err", obs_err, exp_err);
        chk("ar_count", ar_addr_q.size(), (nwords > 1) ? 2 : 1);
        if (ar_addr_q.size() > 0) begin
            chk("ar0_addr", ar_addr_q[0], src);
            chk("ar0_len", ar_len_q[0], 0);
        end
        if (nwords > 1 && ar_addr_q.size() > 1) begin
            chk("ar1_addr", ar_addr_q[1], src + 32'd4);
            chk("ar1_len", ar_len_q[1], nwords - 2);
        end
        if (exp_err) begin
            chk("aw_count_err", aw_addr_q.size(), 0);
            chk("w_count_err", w_data_q.size(), 0);
        end else begin
            chk("aw_count", aw_addr_q.size(), 1);
            if (aw_addr_q.size() > 0) begin
                chk("awaddr", aw_addr_q[0], dst);
                chk("awlen", aw_len_q[0], nbeats - 1);
            end
            chk("w_count", w_data_q.size(), nbeats);
            for (int b = 0; b < nbeats && b < w_data_q.size(); b++) begin
                k = npay - 4 * b;
                if (k > 4) k = 4;
                exp_data = 32'h0; mask = 32'h0;
                for (int i = 0; i < k; i++) begin
                    exp_data = exp_data | (32'(pkt_byte(src, 2 + 4 * b + i)) << (8 * i));
                    mask     = mask | (32'hFF << (8 * i));
                end
                chk("wstrb", w_strb_q[b], (1 << k) - 1);
                chk("wlast", w_last_q[b], (b == nbeats - 1) ? 1 : 0);
                chk("wdata", w_data_q[b] & mask, exp_data);
            end
        end
        chk("done_count", done_cnt, 1);
        chk("no_extra_activity", extra_act, 0);
    endtask

    initial begin
        reset = 1; start = 0; src_addr = 0; dst_addr = 0;
        arready = 0; rdata = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_crc_err", crc_err, 0);
        chk("reset_hdr_byte_cnt", hdr_byte_cnt, 0);
        chk("reset_hdr_data_sel", hdr_data_sel, 0);
        chk("reset_arvalid", arvalid, 0);
        chk("reset_araddr", araddr, 0);
        chk("reset_awvalid", awvalid, 0);
        chk("reset_wvalid", wvalid, 0);
        chk("reset_rready", rready, 0);
        chk("reset_bready", bready, 0);
        reset = 0;

        // Single word, CRC ok
        mem[32'h1000] = 32'h07010000;
        run_txn(32'h1000, 32'h2000, 0, 0, 0, 0, 0);
        check_txn(32'h1000, 32'h2000);
        if (w_data_q.size() > 0) chk("t1_wdata_byte0", w_data_q[0][7:0], 8'h01);

        // Single word, CRC bad
        mem[32'h1100] = 32'h01000000;
        run_txn(32'h1100, 32'h2100, 0, 0, 0, 0, 0);
        check_txn(32'h1100, 32'h2100);
        chk("t2_crc_err", obs_err, 1);

        // Two words, byte_cnt=4, trailer 0x75
        mem[32'h1200] = 32'h00000004;
        mem[32'h1204] = 32'h75000000;
        run_txn(32'h1200, 32'h2200, 0, 0, 0, 0, 0);
        check_txn(32'h1200, 32'h2200);
        chk("t3_crc_err", obs_err, 0);

        // Backpressure on the same packet and on a longer one
        run_txn(32'h1200, 32'h2300, 5, 0, 0, 0, 0);
        check_txn(32'h1200, 32'h2300);
        make_packet(32'h1300, 13, 0);
        run_txn(32'h1300, 32'h2400, 5, 0, 0, 0, 0);
        check_txn(32'h1300, 32'h2400);

        // Reset during W beat 0, then a normal run
        make_packet(32'h1400, 6, 0);
        run_txn(32'h1400, 32'h2500, 0, 0, 0, 0, 1);
        make_packet(32'h1500, 9, 0);
        run_txn(32'h1500, 32'h2600, 0, 0, 0, 0, 0);
        check_txn(32'h1500, 32'h2600);

        // start while busy and start in the done cycle
        make_packet(32'h1600, 11, 0);
        run_txn(32'h1600, 32'h2700, 0, 0, 1, 1, 0);
        check_txn(32'h1600, 32'h2700);

        // Randomized packets and stalls
        for (int t = 0; t < 24; t++) begin
            logic [31:0] s, d;
            int          bc;
            bit          bad;
            s   = 32'h4000 + 32'(t * 64);
            d   = 32'h8000 + 32'(t * 64);
            bc  = (t < 16) ? t : $urandom_range(0, 15);
            bad = ($urandom_range(0, 3) == 0);
            make_packet(s, bc, bad);
            run_txn(s, d, 0, 1, 0, 0, 0);
            check_txn(s, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
